seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_refresh_tick.sv | 48 ++++
 rtl/seven_seg_scan_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants, types and helpers for the multiplexed
//               7-segment scan controller (digit count, nibble width,
//               all-dark anode pattern, leading-zero mask helper).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIB_W      = 4;
    localparam int DATA_W     = NUM_DIGITS * NIB_W;

    // Active-low anodes: all ones turns every digit off.
    localparam logic [NUM_DIGITS-1:0] AN_ALL_DARK = '1;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;

    localparam digit_t LAST_DIGIT = digit_t'(NUM_DIGITS - 1);

    // Bit i set when nibbles i..top are all zero; digit 0 is never flagged.
    function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(
        input logic [DATA_W-1:0] value
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (value[i*NIB_W +: NIB_W] == '0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_refresh_tick.sv
`default_nettype none
// ============================================================================
// Module      : seg_refresh_tick
// Description : Digit-dwell prescaler. Counts 0..CLK_DIV-1 while enabled and
//               flags the last count of each dwell as tick. Held at zero
//               while disabled so a re-enable starts a fresh dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_refresh_tick
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);
    assign cnt  = cnt_q;

    // Next count: wrap at the end of a dwell, park at zero while disabled.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Four-digit multiplexed 7-segment scan controller. Cycles the
//               digit enables with a dark anti-ghosting gap at the start of
//               each dwell, presents the selected nibble to an external
//               decoder, and double-buffers new values so they only take
//               effect on a frame boundary (no mid-frame tearing).
//               Optional build macro: SEG_LEADING_ZERO_BLANK_EN - blanks
//               leading zero digits (digit 0 always lit).
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    output logic                  ready,
    output logic [NIB_W-1:0]      bin_out,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYC);

    logic [CNT_W-1:0]      cnt;
    logic                  tick;

    digit_t                digit_sel_q;
    digit_t                digit_sel_d;
    logic [DATA_W-1:0]     active_q;
    logic [DATA_W-1:0]     active_d;
    logic [DATA_W-1:0]     pending_q;
    logic [DATA_W-1:0]     pending_d;
    logic                  pending_valid_q;
    logic                  pending_valid_d;
    logic [NIB_W-1:0]      bin_out_q;
    logic [NIB_W-1:0]      bin_out_d;
    logic [NUM_DIGITS-1:0] an_n_q;
    logic [NUM_DIGITS-1:0] an_n_d;
    logic [NUM_DIGITS-1:0] blank_mask;

    seg_refresh_tick #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_refresh_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cnt   (cnt),
        .tick  (tick)
    );

    assign frame_done = tick && (digit_sel_q == LAST_DIGIT);
    assign ready      = !pending_valid_q;
    assign bin_out    = bin_out_q;
    assign an_n       = an_n_q;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    assign blank_mask = leading_zero_mask(active_q);
`else
    assign blank_mask = '0;
`endif

    // Digit pointer: step on each dwell tick, park on digit 0 while disabled.
    always_comb begin
        digit_sel_d = digit_sel_q;
        if (!en) begin
            digit_sel_d = '0;
        end else if (tick) begin
            digit_sel_d = digit_sel_q + digit_t'(1);
        end
    end

    // Double buffer: a pending value moves to active only at a frame boundary
    // (or at once while the scan is stopped); new loads wait for a free slot.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if ((frame_done || !en) && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end else if (load && ready) begin
            pending_d       = data_in;
            pending_valid_d = 1'b1;
        end
    end

    // Display outputs for the next cycle: dark during the gap or when stopped.
    always_comb begin
        bin_out_d = active_q[digit_sel_q*NIB_W +: NIB_W];
        an_n_d    = AN_ALL_DARK;
        if (en && (cnt >= GAP_LIM)) begin
            an_n_d = ~(NUM_DIGITS'(1) << digit_sel_q) | blank_mask;
        end
    end

    // State and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_q     <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            bin_out_q       <= '0;
            an_n_q          <= AN_ALL_DARK;
        end else begin
            digit_sel_q     <= digit_sel_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            bin_out_q       <= bin_out_d;
            an_n_q          <= an_n_d;
        end
    end

endmodule
`default_nettype wire
